// File: rtl/ram_dp_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// ram_dp_fifo_ctrl
//
// FIFO controller wrapped around an external single-clock dual-port RAM with
// 1-cycle read latency. Words are written to the RAM on push. Reads are
// prefetched into a two-entry output stage (out register + skid register),
// so pop_valid_o/pop_data_o come straight from flops. Full throughput is one
// push and one pop per cycle, and the latency from push to pop is 3 cycles.
//
// Optional feature macro: RAM_DP_FIFO_CTRL_LEVEL_EN adds the registered
// level_o occupancy output.
//
// Ports
//   clk_i, rst_i       clock; synchronous active-high reset
//   flush_i            synchronous discard of all content
//   push_*             write-side valid/ready handshake and data
//   pop_*              read-side valid/ready handshake and data
//   ram_rd_en_o        RAM read enable, with ram_addr_r_o
//   ram_wr_en_o        RAM write enable, with ram_addr_w_o and ram_data_o
//   ram_data_i         RAM read data, valid the cycle after ram_rd_en_o
//   level_o            total entries held (only with the macro defined)
// ---------------------------------------------------------------------------
module ram_dp_fifo_ctrl #(
  parameter int AddrWidth = 4,
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 push_valid_i,
  output logic                 push_ready_o,
  input  logic [DataWidth-1:0] push_data_i,
  output logic                 pop_valid_o,
  input  logic                 pop_ready_i,
  output logic [DataWidth-1:0] pop_data_o,
  output logic                 ram_rd_en_o,
  output logic                 ram_wr_en_o,
  output logic [AddrWidth-1:0] ram_addr_r_o,
  output logic [AddrWidth-1:0] ram_addr_w_o,
  output logic [DataWidth-1:0] ram_data_o,
`ifdef RAM_DP_FIFO_CTRL_LEVEL_EN
  output logic [AddrWidth+1:0] level_o,
`endif
  input  logic [DataWidth-1:0] ram_data_i
);

  localparam int Depth = 2 ** AddrWidth;
  localparam int PtrW  = AddrWidth + 1;  // pointers and mem_count share this width
  localparam logic [PtrW-1:0] DepthVal = PtrW'(Depth);

  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]      mem_count_q, mem_count_d;
  logic                 rd_inflight_q, rd_inflight_d;
  logic                 out_valid_q, out_valid_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [DataWidth-1:0] out_data_q, out_data_d;
  logic [DataWidth-1:0] skid_data_q, skid_data_d;

  logic       push_fire;
  logic       pop_fire;
  logic       rd_issue;
  logic [1:0] stage_occ;

  // Ready depends only on registered state, so it has no path from pop_ready_i.
  // A read issued while full frees a slot visible only from the next cycle.
  assign push_ready_o = (mem_count_q != DepthVal);
  assign pop_valid_o  = out_valid_q;
  assign pop_data_o   = out_data_q;

  // A push arriving alongside flush or reset is dropped, including its RAM write.
  assign push_fire = push_valid_i && push_ready_o && !flush_i && !rst_i;
  assign pop_fire  = out_valid_q && pop_ready_i;

  // Words already committed to the output stage (or on their way) after this
  // cycle's pop. pop_fire implies out_valid_q, so the subtraction cannot wrap.
  assign stage_occ = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(rd_inflight_q)
                   - 2'(pop_fire);
  assign rd_issue  = (mem_count_q != '0) && (stage_occ < 2'd2) && !flush_i && !rst_i;

  // A read only targets a slot written in an earlier cycle (mem_count != 0),
  // and a write never lands on an unread slot (mem_count != Depth), so the two
  // RAM ports never collide on one address.
  assign ram_wr_en_o  = push_fire;
  assign ram_addr_w_o = wr_ptr_q[AddrWidth-1:0];
  assign ram_data_o   = push_data_i;
  assign ram_rd_en_o  = rd_issue;
  assign ram_addr_r_o = rd_ptr_q[AddrWidth-1:0];

  // NOTE: every signal gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d      = wr_ptr_q + PtrW'(push_fire);
    rd_ptr_d      = rd_ptr_q + PtrW'(rd_issue);
    mem_count_d   = mem_count_q + PtrW'(push_fire) - PtrW'(rd_issue);
    rd_inflight_d = rd_issue;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    skid_valid_d  = skid_valid_q;
    skid_data_d   = skid_data_q;

    // A pop drains out first; a waiting skid word moves up ahead of new data.
    if (pop_fire) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    // Read data lands in out if that slot is free after the pop, else in skid.
    // The issue rule guarantees skid is empty whenever data arrives here.
    if (rd_inflight_q) begin
      if (!out_valid_d) begin
        out_valid_d = 1'b1;
        out_data_d  = ram_data_i;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = ram_data_i;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // Flush and reset share one clear; clearing rd_inflight is what drops the
  // read data still arriving next cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      mem_count_q   <= '0;
      rd_inflight_q <= 1'b0;
      out_valid_q   <= 1'b0;
      skid_valid_q  <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mem_count_q   <= mem_count_d;
      rd_inflight_q <= rd_inflight_d;
      out_valid_q   <= out_valid_d;
      skid_valid_q  <= skid_valid_d;
    end
  end

  // NOTE: data registers carry no reset; their valid bits qualify them, which
  // keeps reset fan-out off the wide datapath.
  always_ff @(posedge clk_i) begin
    out_data_q  <= out_data_d;
    skid_data_q <= skid_data_d;
  end

`ifdef RAM_DP_FIFO_CTRL_LEVEL_EN
  logic [AddrWidth+1:0] level_q, level_d;

  // Built from next-state terms so the registered value matches the current
  // state sum; peaks at Depth + 2 (full RAM plus both output registers).
  always_comb begin
    level_d = (AddrWidth+2)'(mem_count_d) + (AddrWidth+2)'(rd_inflight_d)
            + (AddrWidth+2)'(out_valid_d) + (AddrWidth+2)'(skid_valid_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign level_o = level_q;
`endif

endmodule
